opnd_mem_fetch: RTL and testbench



---
 rtl/opnd_mem_fetch.sv | 149 ++++++++++++++
 tb/tb_opnd_mem_fetch.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opnd_mem_fetch.sv
//----------------------------------------------------------------------------
// Module   : opnd_mem_fetch
// Purpose  : Two-stage operand memory fetch. S1 forms the effective address
//            base + (index << scale) + disp. The disp term is optionally an
//            8-bit sign-extended value, and 16-bit wrap is optional. S2
//            searches a set of hint slots for a read to that address. It
//            returns the hit data masked to the operand size, or a miss.
// Ports    : clk, rst_n (async, active-low)
//            in_valid/in_ready   - request handshake
//            scale, index, base, disp, disp_1byte, addr_16bit, opnd_bytes
//                                - operand address descriptor
//            hint_valid, hint_is_write, hint_address, hint_data
//                                - hint slots, slot k at [32k+31:32k]
//            out_valid/out_ready - response handshake
//            out_addr, out_data, out_miss - response payload
//            miss_count          - saturating miss counter. It exists only
//                                  when OPND_MEM_FETCH_MISS_CNT_EN is defined.
// Config   : `define OPND_MEM_FETCH_MISS_CNT_EN to enable miss_count.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module opnd_mem_fetch #(
  parameter int NUM_HINTS = 2,
  parameter int ADDR_W    = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             scale,
  input  logic [31:0]            index,
  input  logic [31:0]            base,
  input  logic [31:0]            disp,
  input  logic                   disp_1byte,
  input  logic                   addr_16bit,
  input  logic [1:0]             opnd_bytes,
  input  logic [NUM_HINTS-1:0]   hint_valid,
  input  logic [NUM_HINTS-1:0]   hint_is_write,
  input  logic [NUM_HINTS*32-1:0] hint_address,
  input  logic [NUM_HINTS*32-1:0] hint_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_W-1:0]      out_addr,
  output logic [31:0]            out_data,
  output logic                   out_miss
`ifdef OPND_MEM_FETCH_MISS_CNT_EN
  ,
  output logic [15:0]            miss_count
`endif
);

  logic              s1_full;
  logic              s2_full;
  logic [ADDR_W-1:0] s1_ea;
  logic [1:0]        s1_bytes;

  logic              s2_ready;
  logic              s1_load;
  logic              s2_load;

  // A stage may take new contents when empty or when it drains this cycle.
  assign s2_ready  = ~s2_full | out_ready;
  assign in_ready  = ~s1_full | s2_ready;
  assign s1_load   = in_valid & in_ready;
  assign s2_load   = s1_full & s2_ready;
  assign out_valid = s2_full;

  // S1: effective address generation
  logic [31:0]       disp_ext;
  logic [ADDR_W-1:0] ea_sum;
  logic [ADDR_W-1:0] ea_next;

  always_comb begin
    disp_ext = disp_1byte ? {{24{disp[7]}}, disp[7:0]} : disp;
    ea_sum   = ADDR_W'(base) + (ADDR_W'(index) << scale) + ADDR_W'(disp_ext);
    ea_next  = addr_16bit ? ADDR_W'(ea_sum[15:0]) : ea_sum;
  end

  // S2 lookup runs on the S1 address against the hints present this cycle.
  // The scan goes from the top slot downward so that the lowest matching
  // slot is the last to write and therefore wins.
  logic        hit;
  logic [31:0] hit_data;
  logic [31:0] masked_data;

  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int k = NUM_HINTS - 1; k >= 0; k--) begin
      if (hint_valid[k] && !hint_is_write[k] &&
          (ADDR_W'(hint_address[32*k +: 32]) == s1_ea)) begin
        hit      = 1'b1;
        hit_data = hint_data[32*k +: 32];
      end
    end
  end

  always_comb begin
    case (s1_bytes)
      2'd0:    masked_data = {24'h0, hit_data[7:0]};
      2'd1:    masked_data = {16'h0, hit_data[15:0]};
      default: masked_data = hit_data;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_full  <= 1'b0;
      s1_ea    <= '0;
      s1_bytes <= '0;
    end else if (s1_load) begin
      s1_full  <= 1'b1;
      s1_ea    <= ea_next;
      s1_bytes <= opnd_bytes;
    end else if (s2_load) begin
      s1_full  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_full  <= 1'b0;
      out_addr <= '0;
      out_data <= '0;
      out_miss <= 1'b0;
    end else if (s2_load) begin
      s2_full  <= 1'b1;
      out_addr <= s1_ea;
      out_data <= hit ? masked_data : 32'h0;
      out_miss <= ~hit;
    end else if (out_ready) begin
      s2_full  <= 1'b0;
    end
  end

`ifdef OPND_MEM_FETCH_MISS_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_count <= '0;
    end else if (s2_full && out_ready && out_miss && (miss_count != 16'hFFFF)) begin
      miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_opnd_mem_fetch.sv
//----------------------------------------------------------------------------
// Module   : tb_opnd_mem_fetch
// Purpose  : Scoreboard bench for opnd_mem_fetch. It covers directed cases,
//            randomized traffic with backpressure, reset and the optional
//            miss counter.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_opnd_mem_fetch;

  localparam int NH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       scale = '0;
  logic [31:0]      index = '0, base = '0, disp = '0;
  logic             disp_1byte = 1'b0, addr_16bit = 1'b0;
  logic [1:0]       opnd_bytes = '0;
  logic [NH-1:0]    hint_valid, hint_is_write;
  logic [NH*32-1:0] hint_address, hint_data;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      out_addr, out_data;
  logic             out_miss;
`ifdef OPND_MEM_FETCH_MISS_CNT_EN
  logic [15:0]      miss_count;
  int               mc_model = 0;
`endif

  logic        hv[NH];
  logic        hw[NH];
  logic [31:0] ha[NH];
  logic [31:0] hd[NH];
  logic [31:0] pool[4];

  always_comb begin
    hint_valid = '0; hint_is_write = '0; hint_address = '0; hint_data = '0;
    for (int k = 0; k < NH; k++) begin
      hint_valid[k] = hv[k];
      hint_is_write[k] = hw[k];
      hint_address[32*k +: 32] = ha[k];
      hint_data[32*k +: 32] = hd[k];
    end
  end

  opnd_mem_fetch #(.NUM_HINTS(NH), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .scale(scale), .index(index), .base(base), .disp(disp),
    .disp_1byte(disp_1byte), .addr_16bit(addr_16bit), .opnd_bytes(opnd_bytes),
    .hint_valid(hint_valid), .hint_is_write(hint_is_write),
    .hint_address(hint_address), .hint_data(hint_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .out_miss(out_miss)
`ifdef OPND_MEM_FETCH_MISS_CNT_EN
    , .miss_count(miss_count)
`endif
  );

  typedef struct {
    logic [1:0]  sc;
    logic [31:0] ix, bs, dp;
    logic        d1, a16;
    logic [1:0]  nb;
  } req_t;

  typedef struct {
    logic [31:0] addr, data;
    logic        miss;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;
  logic rand_ready = 1'b0;

  // Reference model: plain integer arithmetic plus a first-match search over the hints
  function automatic exp_t model(input req_t r);
    exp_t    e;
    longint  d, ea;
    int      n;
    d  = r.d1 ? longint'($signed(r.dp[7:0])) : longint'(r.dp);
    ea = (longint'(r.bs) + longint'(r.ix) * (longint'(1) << r.sc) + d) & 64'hFFFF_FFFF;
    if (r.a16) ea = ea % 65536;
    e.addr = 32'(ea);
    e.data = 32'h0;
    e.miss = 1'b1;
    n = (r.nb == 2'd0) ? 1 : (r.nb == 2'd1) ? 2 : 4;
    for (int k = 0; k < NH; k++) begin
      if (e.miss && hv[k] && !hw[k] && ha[k] == e.addr) begin
        e.miss = 1'b0;
        e.data = (n == 4) ? hd[k] : 32'(longint'(hd[k]) % (longint'(1) << (8 * n)));
      end
    end
    return e;
  endfunction

  function automatic req_t mk(input logic [31:0] bs, ix, dp, input logic [1:0] sc,
                              input logic d1, a16, input logic [1:0] nb);
    req_t r;
    r.bs = bs; r.ix = ix; r.dp = dp; r.sc = sc; r.d1 = d1; r.a16 = a16; r.nb = nb;
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t        r;
    logic [31:0] tgt;
    longint      d;
    r.sc  = 2'($urandom);
    r.ix  = $urandom;
    r.dp  = $urandom;
    r.d1  = 1'($urandom_range(0, 1));
    r.a16 = ($urandom_range(0, 3) == 0);
    r.nb  = 2'($urandom);
    tgt   = pool[$urandom_range(0, 3)];
    d     = r.d1 ? longint'($signed(r.dp[7:0])) : longint'(r.dp);
    r.bs  = 32'(longint'(tgt) - longint'(r.ix) * (longint'(1) << r.sc) - d);
    if ($urandom_range(0, 3) == 0) r.bs = $urandom;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, req);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge with in_valid low.
  task automatic send(input req_t r);
    int n = 0;
    scale = r.sc; index = r.ix; base = r.bs; disp = r.dp;
    disp_1byte = r.d1; addr_16bit = r.a16; opnd_bytes = r.nb;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout: in_ready stuck low");
    end else begin
      sbq.push_back(model(r));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sbq.size() != 0 || out_valid) && n < 500) begin @(negedge clk); n++; end
    total++;
    if (sbq.size() != 0 || out_valid) begin
      bad++;
      $display("FAIL drain: %0d outputs still pending", sbq.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic clear_hints();
    for (int k = 0; k < NH; k++) begin hv[k] = 0; hw[k] = 0; ha[k] = '0; hd[k] = '0; end
  endtask

  // Monitor: compare every completed output transfer and check hold stability under stall
  logic        have_hold = 1'b0;
  logic [31:0] h_addr, h_data;
  logic        h_miss;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        have_hold = 1'b0;
      end else begin
        if (have_hold) begin
          total++;
          if (!(out_valid && out_addr == h_addr && out_data == h_data && out_miss == h_miss)) begin
            bad++;
            $display("FAIL hold: got v=%0b a=0x%08h d=0x%08h m=%0b want v=1 a=0x%08h d=0x%08h m=%0b",
                     out_valid, out_addr, out_data, out_miss, h_addr, h_data, h_miss);
          end
        end
        have_hold = 1'b0;
        if (out_valid && out_ready) begin
          total++;
          if (sbq.size() == 0) begin
            bad++;
            $display("FAIL unexpected_out: got a=0x%08h with nothing expected", out_addr);
          end else begin
            e = sbq.pop_front();
            if (out_addr !== e.addr || out_data !== e.data || out_miss !== e.miss) begin
              bad++;
              $display("FAIL out: got a=0x%08h d=0x%08h m=%0b want a=0x%08h d=0x%08h m=%0b",
                       out_addr, out_data, out_miss, e.addr, e.data, e.miss);
            end
`ifdef OPND_MEM_FETCH_MISS_CNT_EN
            if (e.miss && mc_model < 65535) mc_model++;
`endif
          end
        end else if (out_valid) begin
          have_hold = 1'b1;
          h_addr = out_addr; h_data = out_data; h_miss = out_miss;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #2;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    req_t r;
    clear_hints();
    for (int j = 0; j < 4; j++) pool[j] = $urandom;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_out_addr", out_addr, 32'h0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_miss", 32'(out_miss), 32'h0);
    @(posedge clk); #1;

    // 1-byte disp, 4-byte operand, slot 0 hit; also a 2-cycle latency check
    hv[0] = 1; ha[0] = 32'h103C; hd[0] = 32'hAABBCCDD;
    send(mk(32'h1000, 32'h10, 32'hFC, 2'd2, 1'b1, 1'b0, 2'd2));
    @(negedge clk); check("latency_c1", 32'(out_valid), 32'h0);
    @(negedge clk); check("latency_c2", 32'(out_valid), 32'h1);
    @(posedge clk); #1;
    drain();

    // Write slot is skipped, slot 1 hit, 1-byte mask
    hw[0] = 1; hv[1] = 1; ha[1] = 32'h103C; hd[1] = 32'h11223344;
    send(mk(32'h1000, 32'h10, 32'hFC, 2'd2, 1'b1, 1'b0, 2'd0));
    drain();

    // 16-bit wrap with a miss
    clear_hints();
    send(mk(32'hFFFF, 32'h0, 32'h2, 2'd0, 1'b1, 1'b1, 2'd2));
    drain();

    // Backpressure: three requests, output stalled for 4 cycles
    hv[0] = 1; ha[0] = 32'h20; hd[0] = 32'hCAFEF00D;
    out_ready = 1'b0;
    send(mk(32'h20, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 2'd1));
    send(mk(32'h30, 32'h1, 32'h0, 2'd3, 1'b0, 1'b0, 2'd2));
    check("stall_in_ready", 32'(in_ready), 32'h0);
    r = mk(32'h10, 32'h4, 32'hC, 2'd0, 1'b0, 1'b0, 2'd3);
    fork
      send(r);
    join_none
    repeat (4) @(posedge clk);
    #1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); check("consecutive_out", 32'(out_valid), 32'h1);
    end
    wait fork;
    @(posedge clk); #1;
    drain();

    // Reset with two requests in flight
    out_ready = 1'b0;
    send(mk(32'h100, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 2'd2));
    send(mk(32'h200, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 2'd2));
    #2; rst_n = 1'b0;
    #1; check("reset_async", 32'(out_valid), 32'h0);
    sbq.delete();
`ifdef OPND_MEM_FETCH_MISS_CNT_EN
    mc_model = 0;
`endif
    out_ready = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    begin
      int seen = 0;
      repeat (5) begin @(negedge clk); if (out_valid) seen++; end
      check("post_reset_quiet", 32'(seen), 32'h0);
    end
    @(posedge clk); #1;

    // Randomized traffic with random backpressure; hints change only when idle
    for (int ph = 0; ph < 20; ph++) begin
      pool[0] = 32'($urandom_range(0, 65535));
      pool[1] = 32'($urandom_range(0, 65535));
      pool[2] = $urandom;
      pool[3] = $urandom;
      for (int k = 0; k < NH; k++) begin
        hv[k] = 1'($urandom_range(0, 3) != 0);
        hw[k] = 1'($urandom_range(0, 3) == 0);
        ha[k] = pool[$urandom_range(0, 3)];
        hd[k] = $urandom;
      end
      rand_ready = 1'b1;
      for (int i = 0; i < 30; i++) begin
        send(rand_req());
        if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      end
      rand_ready = 1'b0;
      #2; out_ready = 1'b1;
      @(posedge clk); #1;
      drain();
    end

`ifdef OPND_MEM_FETCH_MISS_CNT_EN
    check("miss_count", 32'(miss_count), 32'(mc_model));
    clear_hints();
    for (int i = 0; i < 32'h10002; i++) send(rand_req());
    drain();
    check("miss_count_sat", 32'(miss_count), 32'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
